// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch monitor: event-word sizing and a
// saturating increment used by the run-length and glitch counters.
package glitch_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int TS_W_DEF     = 12;
    localparam int EVT_W        = CHANNELS_DEF + TS_W_DEF;

    // Event word is {glitch mask, timestamp}
    function automatic int evt_width(input int channels, input int ts_w);
        return channels + ts_w;
    endfunction

    // Increment v, holding at 2^w-1 (w < 32 expected)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        if (w >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << w) - 32'd1;
        end
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/glitch_event_fifo.sv
// Small event FIFO with valid/ready output. A push is accepted when not full
// or when a pop happens in the same cycle; a rejected push raises drop_o.
module glitch_event_fifo
    import glitch_pkg::*;
#(
    parameter int W     = EVT_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         drop_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         pop;
    logic         accept;

    // Extra pointer bit distinguishes full from empty
    assign valid_o = (wr_q != rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = valid_o & ready_i;
    assign accept  = push_i & (~full_o | pop);
    assign drop_o  = push_i & ~accept & ~clr_i;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (accept) begin
                wr_d = wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_d = rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; only the pointers define contents
    always_ff @(posedge clk) begin
        if (accept && !clr_i) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/glitch_monitor.sv
// Multi-channel glitch monitor: per-channel pulse-width tracking, saturating
// glitch counters, and a timestamped event FIFO drained by valid/ready.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int RUN_W    = 3,
    parameter int TS_W     = 12,
    parameter int DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHANNELS-1:0]                in_data,
    input  logic                               en,
    input  logic [RUN_W-1:0]                   thresh,
    input  logic                               clr,
    output logic [CHANNELS*CNT_W-1:0]          counts,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic [evt_width(CHANNELS,TS_W)-1:0] evt_data,
    output logic                               overflow
);

    localparam int EW = evt_width(CHANNELS, TS_W);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [CHANNELS-1:0] glitch;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic                overflow_q, overflow_d;
    logic                push;
    logic                fifo_full;
    logic                fifo_drop;
    logic                unused_fifo_full;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic             lvl_q, lvl_d;
        logic             armed_q, armed_d;
        logic [RUN_W-1:0] run_q, run_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             ch_edge;

        assign ch_edge = (in_data[gi] != lvl_q);
        // A saturated run length counts as longer than any threshold
        assign glitch[gi] = ch_edge & armed_q & (thresh != '0)
                          & (run_q <= thresh) & (run_q != RUN_MAX);

        assign lvl_d   = in_data[gi];
        assign armed_d = armed_q | ch_edge;
        assign run_d   = ch_edge ? RUN_W'(1) : RUN_W'(sat_inc(32'(run_q), RUN_W));

        always_comb begin
            count_d = count_q;
            if (clr) begin
                count_d = '0;
            end else if (en && glitch[gi]) begin
                count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl_q   <= 1'b0;
                armed_q <= 1'b0;
                run_q   <= '0;
                count_q <= '0;
            end else begin
                lvl_q   <= lvl_d;
                armed_q <= armed_d;
                run_q   <= run_d;
                count_q <= count_d;
            end
        end

        assign counts[gi*CNT_W +: CNT_W] = count_q;
    end

    assign ts_d       = ts_q + TS_W'(1);
    assign push       = en & (|glitch);
    assign overflow_d = clr ? 1'b0 : (overflow_q | fifo_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    glitch_event_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .push_i      (push),
        .push_data_i ({glitch, ts_q}),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop),
        .valid_o     (evt_valid),
        .ready_i     (evt_ready),
        .data_o      (evt_data)
    );

    // Overflow is derived from the drop flag; full is informational only
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_glitch_monitor.sv
// Bench for glitch_monitor: directed scenarios plus random traffic, checked
// each cycle against a pulse-width / queue reference model.
module tb_glitch_monitor;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int RW = 3;
    localparam int TW = 12;
    localparam int DP = 4;
    localparam int EW = CH + TW;
    localparam int RUN_SAT = 7;
    localparam int CNT_MAX = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     in_data = '0;
    logic              en = 1'b0;
    logic [RW-1:0]     thresh = '0;
    logic              clr = 1'b0;
    logic [CH*CW-1:0]  counts;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [EW-1:0]     evt_data;
    logic              overflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit            m_lvl [CH];
    bit            m_armed [CH];
    int            m_last [CH];
    int            m_cnt [CH];
    int            m_n;
    logic [EW-1:0] m_q [$];
    bit            m_ovf;
    bit            verbose = 1'b1;

    logic          en_v = 1'b1;
    logic [RW-1:0] thr_v = 3'd1;
    logic          ready_v = 1'b0;
    logic [CH-1:0] cur;

    glitch_monitor #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .RUN_W    (RW),
        .TS_W     (TW),
        .DEPTH    (DP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .en        (en),
        .thresh    (thresh),
        .clr       (clr),
        .counts    (counts),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return counts[c*CW +: CW];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_lvl[c] = 1'b0;
            m_armed[c] = 1'b0;
            m_last[c] = 0;
            m_cnt[c] = 0;
        end
        m_n = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // One clock edge: pulse width is the distance in edges since the last transition
    task automatic model_step();
        logic [CH-1:0] mask;
        bit            pop;
        int            d;
        mask = '0;
        pop = evt_ready && (m_q.size() > 0);
        for (int c = 0; c < CH; c++) begin
            if (in_data[c] != m_lvl[c]) begin
                d = m_n - m_last[c];
                if (m_armed[c] && thresh != 0 && d <= int'(thresh) && d < RUN_SAT)
                    mask[c] = 1'b1;
                m_lvl[c] = in_data[c];
                m_last[c] = m_n;
                m_armed[c] = 1'b1;
            end
        end
        if (clr) begin
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++)
                if (en && mask[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
            if (pop) begin
                if (verbose)
                    $display("evt pop mask=%b ts=%0d", m_q[0][EW-1:TW], m_q[0][TW-1:0]);
                void'(m_q.pop_front());
            end
            if (en && mask != 0) begin
                if (m_q.size() < DP) m_q.push_back({mask, TW'(m_n)});
                else m_ovf = 1'b1;
            end
        end
        m_n++;
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) check($sformatf("count%0d", c), cnt_of(c), m_cnt[c]);
        check("evt_valid", evt_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check("evt_data", evt_data, m_q[0]);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic [CH-1:0] v, input logic clr_i);
        in_data = v;
        clr = clr_i;
        en = en_v;
        thresh = thr_v;
        evt_ready = ready_v;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [CH-1:0] v, input int k);
        for (int i = 0; i < k; i++) step(v, 1'b0);
    endtask

    task automatic toggle0(input int k);
        for (int i = 0; i < k; i++) begin
            cur[0] = ~cur[0];
            step(cur, 1'b0);
        end
    endtask

    initial begin
        logic [TW-1:0] prev_ts;
        bit            have_prev;

        model_reset();
        cur = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();

        // Single 1-cycle pulse on ch0 after a prior edge
        thr_v = 3'd1; ready_v = 1'b0; en_v = 1'b1;
        hold(4'b0000, 3);
        hold(4'b0001, 3);
        hold(4'b0000, 3);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("tp1_cnt0", cnt_of(0), 1);
        check("tp1_cnt1", cnt_of(1), 0);
        check("tp1_mask", evt_data[EW-1:TW], 4'b0001);
        check("tp1_ts", evt_data[TW-1:0], TW'(m_n - 1));

        // Widths 3 and 4 against thresh 3
        thr_v = 3'd3; ready_v = 1'b1;
        hold(4'b0100, 5); hold(4'b0000, 5);
        hold(4'b0100, 3); hold(4'b0000, 5);
        hold(4'b0100, 4); hold(4'b0000, 5);
        check("tp2_cnt2", cnt_of(2), 1);

        // ch1 and ch3 closing on the same edge
        thr_v = 3'd2; ready_v = 1'b0;
        hold(4'b1010, 4); hold(4'b0000, 4);
        hold(4'b1010, 2); step(4'b0000, 1'b0);
        check("tp3_valid", evt_valid, 1'b1);
        check("tp3_mask", evt_data[EW-1:TW], 4'b1010);
        check("tp3_cnt1", cnt_of(1), 1);
        check("tp3_cnt3", cnt_of(3), 1);

        // Overflow with consumer stalled, then ordered drain
        step(4'b0000, 1'b1);
        thr_v = 3'd1;
        cur = '0;
        toggle0(6);
        check("tp4_overflow", overflow, 1'b1);
        check("tp4_valid", evt_valid, 1'b1);
        ready_v = 1'b1;
        have_prev = 1'b0;
        prev_ts = '0;
        for (int i = 0; i < 5; i++) begin
            if (evt_valid) begin
                if (have_prev) check("tp4_ts_order", (evt_data[TW-1:0] > prev_ts), 1'b1);
                prev_ts = evt_data[TW-1:0];
                have_prev = 1'b1;
            end
            step(cur, 1'b0);
        end
        check("tp4_drained", evt_valid, 1'b0);

        // Counter saturation
        verbose = 1'b0;
        toggle0(300);
        check("tp5_sat", cnt_of(0), CNT_MAX);
        verbose = 1'b1;

        // Clear on the same edge as a glitch, tracking survives
        ready_v = 1'b0;
        toggle0(6);
        check("tp6_ovf_pre", overflow, 1'b1);
        hold(4'b0000, 3);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1);
        check("tp6_counts", counts, '0);
        check("tp6_valid", evt_valid, 1'b0);
        check("tp6_ovf", overflow, 1'b0);
        hold(4'b0000, 3);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("tp6_rearm", cnt_of(0), 1);

        // Random traffic
        verbose = 1'b0;
        cur = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) thr_v = RW'($urandom_range(0, 7));
            en_v = ($urandom_range(0, 9) != 0);
            ready_v = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 9) < 3) cur[c] = ~cur[c];
            step(cur, ($urandom_range(0, 199) == 0));
        end
        verbose = 1'b1;

        // Asynchronous reset mid-operation
        en_v = 1'b1; thr_v = 3'd1; ready_v = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_counts", counts, '0);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        #1;
        rst_n = 1'b1;
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        check("rst_unarmed", cnt_of(0), 0);
        step(4'b0000, 1'b0);
        check("rst_pulse", cnt_of(0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glitch_monitor.md
# glitch_monitor

Multi-channel, parametrised glitch monitor for the logic-analyzer capture path. Each input channel is checked for short pulses: a level held for at least 1 and at most `thresh` cycles, with a transition at both ends. Glitches increment per-channel saturating counters. Each cycle with at least one glitch pushes a timestamped event word into a small FIFO, which the readout logic drains through a valid/ready handshake.

## Interface
Parameters:
- `CHANNELS`, 4: number of monitored input bits.
- `CNT_W`, 8: width of each per-channel glitch counter.
- `RUN_W`, 3: width of the run-length counter and of `thresh`.
- `TS_W`, 12: width of the free-running timestamp.
- `DEPTH`, 4: event FIFO depth, a power of two and at least 2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_data`, in, CHANNELS: monitored signals, already synchronous to `clk`.
- `en`, in, 1: enables counting and event pushes.
- `thresh`, in, RUN_W: maximum glitch width in cycles; 0 disables detection.
- `clr`, in, 1: synchronous clear of counters, FIFO and overflow.
- `counts`, out, CHANNELS*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W].
- `evt_valid`, out, 1: FIFO not empty.
- `evt_ready`, in, 1: consumer accepts the head entry.
- `evt_data`, out, CHANNELS+TS_W: head entry, {glitch mask, timestamp}.
- `overflow`, out, 1: sticky; an event was dropped.

## Operation
Per-channel state:
- `lvl`: last sampled level.
- `run`: cycles `lvl` has been held, saturating at 2^RUN_W-1.
- `armed`: set once any transition has been seen.

Detection, evaluated at every posedge for each channel i:
- `edge_i = in_data[i] != lvl[i]`.
- `glitch_i = edge_i & armed_i & (thresh != 0) & (run_i <= thresh)`.
- On an edge: `lvl <= in_data[i]`, `run <= 1`, `armed <= 1`.
- Otherwise `run` increments, saturating.
- Tracking runs regardless of `en` and `clr`.
- The first level after reset is never counted, because its start is unknown.
- A saturated `run` never qualifies, because `thresh` is at most 2^RUN_W-1 and a saturated run is treated as longer than that.

Counting:
- When `en & glitch_i`, `count_i` increments.
- `count_i` saturates at 2^CNT_W-1 and never wraps.

Timestamp:
- `ts` is free-running and increments every cycle, wrapping modulo 2^TS_W.
- `clr` does not affect it.

Events:
- If `en` and the glitch mask `m` is nonzero, push {m, ts} into the FIFO.
- `ts` is the value before the edge that detected the glitch.
- One entry is pushed per cycle regardless of how many channels glitch simultaneously.

FIFO:
- A pop occurs when `evt_valid & evt_ready`.
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Push and pop in the same cycle leave the occupancy unchanged.
- A rejected push sets `overflow`; the FIFO contents are unchanged.
- `evt_data` is don't-care while `evt_valid` is 0; it is driven from the head register.

Clear:
- `clr` zeroes all counts, empties the FIFO and clears `overflow`.
- `clr` has priority over any count, push or overflow event in the same cycle.
- Channel tracking state (`lvl`, `run`, `armed`) is preserved.

Changing `thresh` takes effect at the next edge evaluation.

## Timing
- Reset values:
  - `counts`, `evt_valid` and `overflow` are 0.
  - `lvl`, `run`, `armed`, `ts` and the FIFO pointers are 0.
- Pulse example: `in_data[i]` is high only across posedge k, meaning set before edge k and cleared before edge k+1.
  - The rise is seen at edge k.
  - The fall is seen at edge k+1 with `run` = 1, so a glitch is declared.
  - The new count and `evt_valid` are visible after edge k+1.
- Latency from the closing transition to the updated outputs: 1 cycle, since all outputs are registered.
- A pushed entry may be popped in the cycle after the push, at the earliest.
- Asynchronous reset mid-operation discards all state, including FIFO contents and `armed`.

## Structure
- `glitch_pkg` holds the event-word width localparam (CHANNELS+TS_W) and a saturating-increment function.
- One sub-module, `glitch_event_fifo`: parametrised in width and depth, valid/ready output, `push`, `full`, `clr` and a drop indication.
- The channel tracking logic is a generate loop in the top module.

## Test plan
- `thresh`=1, single 1-cycle high pulse on ch0 after a prior edge:
  - `counts[0]` = 1.
  - One event with mask 4'b0001 and the `ts` of the detecting cycle.
  - Other counters stay 0.
- `thresh`=3 with pulses of widths 3 and 4 on ch2 → only the width-3 pulse is counted; `counts[2]` = 1.
- Glitches on ch1 and ch3 closing on the same edge → a single event with mask 4'b1010; both counters +1.
- `evt_ready`=0 with DEPTH+1 glitch cycles → 4 entries held, `overflow`=1. Drain afterwards → entries come out in order with increasing `ts`.
- Force `count_0` to 255 with CNT_W=8, then one more glitch → it stays 255.
- `clr` asserted in the same cycle as a glitch → counts 0, FIFO empty, `overflow` 0. Then a 1-cycle pulse is detected normally, since `armed` is preserved.
